// File: rtl/ripple_adder_sched.sv
// Time-shares one 4-bit ripple-carry slice between two requesters, sequencing
// WIDTH-bit additions nibble by nibble with a registered inter-nibble carry.

module ripple_adder_sched_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    always_comb begin : ripple
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module ripple_adder_sched #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              last;
    logic              owner;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  partial;

    logic              capture;
    logic              winner;
    logic              last_nib;
    logic [WIDTH-1:0]  a_shift;
    logic [WIDTH-1:0]  b_shift;
    logic [3:0]        slice_sum;
    logic              slice_cout;
    logic [WIDTH-1:0]  partial_next;

    ripple_adder_sched_slice u_slice (
        .a    (a_shift[3:0]),
        .b    (b_shift[3:0]),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        winner     = (req0 && req1) ? ~last : req1;
        unique case (state)
            S_IDLE: if (req0 || req1) begin
                capture    = 1'b1;
                next_state = S_RUN;
            end
            S_RUN:  if (last_nib) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign last_nib     = (idx == IDXW'(NIB - 1));
    assign a_shift      = op_a >> {idx, 2'b00};
    assign b_shift      = op_b >> {idx, 2'b00};
    assign partial_next = partial | (WIDTH'(slice_sum) << {idx, 2'b00});
    assign busy         = (state != S_IDLE);

    // Reset clears last to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= 1'b1;
            owner   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            partial <= '0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            ack0 <= capture && !winner;
            ack1 <= capture && winner;
            done <= 1'b0;
            if (capture) begin
                op_a    <= winner ? a1 : a0;
                op_b    <= winner ? b1 : b0;
                carry   <= winner ? cin1 : cin0;
                idx     <= '0;
                partial <= '0;
                owner   <= winner;
                last    <= winner;
            end else if (state == S_RUN) begin
                carry   <= slice_cout;
                partial <= partial_next;
                idx     <= idx + IDXW'(1);
                if (last_nib) begin
                    sum     <= partial_next;
                    cout    <= slice_cout;
                    done    <= 1'b1;
                    done_id <= owner;
                end
            end
        end
    end

endmodule

// File: tb/tb_ripple_adder_sched.sv
// Scoreboard bench: stimulus queues hand-computed results, monitors compare on DONE.

module tb_ripple_adder_sched;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        id;
    } exp16_t;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       id;
    } exp4_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, cin0, cin1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, busy, done, done_id, cout;
    logic [15:0] sum;

    logic        w4_req0, w4_req1, w4_cin0, w4_cin1;
    logic [3:0]  w4_a0, w4_b0, w4_a1, w4_b1;
    logic        w4_ack0, w4_ack1, w4_busy, w4_done, w4_done_id, w4_cout;
    logic [3:0]  w4_sum;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    exp16_t q16[$];
    exp4_t  q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ripple_adder_sched #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .cin0(cin0),
        .req1(req1), .a1(a1), .b1(b1), .cin1(cin1),
        .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
        .done_id(done_id), .sum(sum), .cout(cout)
    );

    ripple_adder_sched #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst),
        .req0(w4_req0), .a0(w4_a0), .b0(w4_b0), .cin0(w4_cin0),
        .req1(w4_req1), .a1(w4_a1), .b1(w4_b1), .cin1(w4_cin1),
        .ack0(w4_ack0), .ack1(w4_ack1), .busy(w4_busy), .done(w4_done),
        .done_id(w4_done_id), .sum(w4_sum), .cout(w4_cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the 16-bit instance.
    exp16_t e16;
    int     ack_cyc16 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ack0 || ack1) begin
                check("ack_exclusive", 32'(ack0 & ack1), 0);
                ack_cyc16 = cyc;
            end
            if (done) begin
                if (q16.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e16 = q16.pop_front();
                    check("sum", 32'(sum), 32'(e16.sum));
                    check("cout", 32'(cout), 32'(e16.cout));
                    check("done_id", 32'(done_id), 32'(e16.id));
                    check("done_busy", 32'(busy), 1);
                    check("done_latency", 32'(cyc - ack_cyc16), 4);
                end
            end
        end
    end

    // Monitor for the 4-bit instance.
    exp4_t e4;
    int    ack_cyc4 = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (w4_ack0 || w4_ack1) ack_cyc4 = cyc;
            if (w4_done) begin
                if (q4.size() == 0) begin
                    check("w4_unexpected_done", 1, 0);
                end else begin
                    e4 = q4.pop_front();
                    check("w4_sum", 32'(w4_sum), 32'(e4.sum));
                    check("w4_cout", 32'(w4_cout), 32'(e4.cout));
                    check("w4_done_id", 32'(w4_done_id), 32'(e4.id));
                    check("w4_done_latency", 32'(cyc - ack_cyc4), 1);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input bit which, output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (which ? ack1 : ack0) begin
                seen = 1'b1;
                at   = cyc;
            end
        end
        if (!seen) check(which ? "ack1_timeout" : "ack0_timeout", 0, 1);
    endtask

    task automatic wait_any(output bit who);
        bit seen = 1'b0;
        who = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ack0 || ack1) begin
                seen = 1'b1;
                who  = ack1;
            end
        end
        if (!seen) check("grant_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q16.size() != 0 || q4.size() != 0); i++) tick();
        check("drain", 32'(q16.size() + q4.size()), 0);
        tick();
        tick();
    endtask

    logic [15:0] t4_a0 [2] = '{16'h0F0F, 16'hABCD};
    logic [15:0] t4_b0 [2] = '{16'h00F1, 16'h1111};
    logic        t4_c0 [2] = '{1'b0, 1'b1};
    logic [15:0] t4_a1 [2] = '{16'h8001, 16'hFFFE};
    logic [15:0] t4_b1 [2] = '{16'h7FFF, 16'h0001};
    logic        t4_c1 [2] = '{1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, p0, p1;
        bit who;
        rst = 1'b1;
        {req0, req1, cin0, cin1} = '0;
        {a0, b0, a1, b1} = '0;
        {w4_req0, w4_req1, w4_cin0, w4_cin1} = '0;
        {w4_a0, w4_b0, w4_a1, w4_b1} = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_outputs", 32'({ack0, ack1, busy, done, done_id, cout, sum}), 0);

        // Basic addition on requester 0, with BUSY tracked over the operation.
        a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b0;
        q16.push_back('{16'h5555, 1'b0, 1'b0});
        req0 = 1'b1;
        wait_ack(0, t0);
        req0 = 1'b0;
        check("t1_busy_ack", 32'(busy), 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_busy_run", 32'(busy), 1);
            if (k == 1) check("t1_ack_pulse", 32'(ack0), 0);
        end
        tick();
        check("t1_busy_idle", 32'(busy), 0);
        drain();

        // Full carry ripple on requester 1.
        a1 = 16'hFFFF; b1 = 16'h0000; cin1 = 1'b1;
        q16.push_back('{16'h0000, 1'b1, 1'b1});
        req1 = 1'b1;
        wait_ack(1, t1);
        req1 = 1'b0;
        drain();

        // Contested start after reset: requester 0 first, then 1, six cycles apart.
        do_reset();
        a0 = 16'h0001; b0 = 16'h0002; cin0 = 1'b0;
        a1 = 16'h7FFF; b1 = 16'h0001; cin1 = 1'b1;
        q16.push_back('{16'h0003, 1'b0, 1'b0});
        q16.push_back('{16'h8001, 1'b0, 1'b1});
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack(0, t0);
        check("t3_no_ack1_first", 32'(ack1), 0);
        req0 = 1'b0;
        wait_ack(1, t1);
        req1 = 1'b0;
        check("t3_ack_gap", 32'(t1 - t0), 6);
        drain();

        // Both requesters keep re-raising: grants alternate 0,1,0,1.
        q16.push_back('{16'h1000, 1'b0, 1'b0});
        q16.push_back('{16'h0000, 1'b1, 1'b1});
        q16.push_back('{16'hBCDF, 1'b0, 1'b0});
        q16.push_back('{16'hFFFF, 1'b0, 1'b1});
        p0 = 0; p1 = 0;
        a0 = t4_a0[0]; b0 = t4_b0[0]; cin0 = t4_c0[0];
        a1 = t4_a1[0]; b1 = t4_b1[0]; cin1 = t4_c1[0];
        req0 = 1'b1;
        req1 = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_any(who);
            check("t4_grant_order", 32'(who), 32'(g % 2));
            if (who) begin req1 = 1'b0; p1++; end
            else     begin req0 = 1'b0; p0++; end
            tick();
            if (!who && p0 < 2) begin
                a0 = t4_a0[p0]; b0 = t4_b0[p0]; cin0 = t4_c0[p0]; req0 = 1'b1;
            end
            if (who && p1 < 2) begin
                a1 = t4_a1[p1]; b1 = t4_b1[p1]; cin1 = t4_c1[p1]; req1 = 1'b1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        drain();

        // Reset mid-RUN abandons the operation; the next one still works.
        a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
        req0 = 1'b1;
        wait_ack(0, t0);
        req0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_sum_cleared", 32'(sum), 0);
        check("t5_cout_cleared", 32'(cout), 0);
        check("t5_busy_cleared", 32'(busy), 0);
        check("t5_done_low", 32'(done), 0);
        repeat (6) tick();
        a1 = 16'h8000; b1 = 16'h8000; cin1 = 1'b0;
        q16.push_back('{16'h0000, 1'b1, 1'b1});
        req1 = 1'b1;
        wait_ack(1, t1);
        req1 = 1'b0;
        drain();

        // WIDTH=4 build: single RUN cycle.
        w4_a0 = 4'hF; w4_b0 = 4'h1; w4_cin0 = 1'b0;
        q4.push_back('{4'h0, 1'b1, 1'b0});
        w4_req0 = 1'b1;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                seen = w4_ack0;
            end
            if (!seen) check("w4_ack0_timeout", 0, 1);
        end
        w4_req0 = 1'b0;
        drain();

        check("final_queues_empty", 32'(q16.size() + q4.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
